// File: rtl/eth_word_packer.sv
// eth_word_packer
// ---------------------------------------------------------------------------
// Receive-path stage that follows the MAC-address filter. It takes the
// filter's MSB-first dibit stream (ethertype + payload + FCS) and strips the
// trailing 32-bit FCS. The remaining bytes are packed into 32-bit words, with
// the first byte in [31:24]. The last word of a frame carries a last flag and
// a valid-byte count. Frames shorter than 16 dibits are reported as runts.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   axiiv        dibit valid; high for the whole frame body, low between frames
//   axiid[1:0]   dibit data, MSB-first within each byte
//   axiov        word valid, one-cycle pulse
//   axiod[31:0]  word data, left-aligned, zero-padded beyond the valid bytes
//   axiod_last   marks the final word of the frame (qualified by axiov)
//   axiod_bytes  valid bytes in axiod, 1..4 (qualified by axiov)
//   runt         one-cycle pulse: the frame ended with fewer than 16 dibits
// ---------------------------------------------------------------------------
module eth_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [31:0] axiod,
    output logic        axiod_last,
    output logic [2:0]  axiod_bytes,
    output logic        runt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;

    // FCS delay line: holds the newest 16 dibits, which might still be FCS
    logic [31:0] dly_q, dly_d;
    logic [4:0]  fill_q, fill_d;

    // Packer and its single pending full word
    logic [31:0] pack_q, pack_d;
    logic [4:0]  pcnt_q, pcnt_d;
    logic [31:0] pend_q, pend_d;
    logic        pendv_q, pendv_d;

    // Registered outputs
    logic        axiov_q, axiov_d;
    logic [31:0] axiod_q, axiod_d;
    logic        last_q, last_d;
    logic [2:0]  bytes_q, bytes_d;
    logic        runt_q, runt_d;

    // Partial word: left-align the packed dibits and keep only whole bytes.
    // Any trailing 1-3 dibits that do not form a byte are masked off.
    logic [2:0]  part_bytes;
    logic [5:0]  part_sh;
    logic [31:0] part_mask;
    logic [31:0] part_data;

    assign part_bytes = 3'(pcnt_q >> 2);
    assign part_sh    = 6'd32 - {pcnt_q, 1'b0};
    assign part_mask  = ~(32'hFFFF_FFFF >> {part_bytes, 3'b000});
    assign part_data  = (pack_q << part_sh) & part_mask;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        fill_d  = fill_q;
        pack_d  = pack_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;
        pendv_d = pendv_q;
        axiov_d = 1'b0;
        axiod_d = axiod_q;
        last_d  = last_q;
        bytes_d = bytes_q;
        runt_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (axiiv) state_d = S_FRAME;
            end

            S_FRAME: begin
                if (!axiiv) begin
                    // End edge. Discard everything by default; the branches
                    // below decide what is released first.
                    state_d = S_IDLE;
                    dly_d   = '0;
                    fill_d  = '0;
                    pack_d  = '0;
                    pcnt_d  = '0;
                    pendv_d = 1'b0;
                    if (fill_q < 5'd16) begin
                        runt_d = 1'b1;
                    end else if (pendv_q) begin
                        axiov_d = 1'b1;
                        axiod_d = pend_q;
                        bytes_d = 3'd4;
                        if (pcnt_q >= 5'd4) begin
                            // Partial word still to come: emit it in FLUSH.
                            last_d  = 1'b0;
                            state_d = S_FLUSH;
                            pack_d  = pack_q;
                            pcnt_d  = pcnt_q;
                        end else begin
                            last_d = 1'b1;
                        end
                    end else if (pcnt_q >= 5'd4) begin
                        axiov_d = 1'b1;
                        axiod_d = part_data;
                        last_d  = 1'b1;
                        bytes_d = part_bytes;
                    end
                end
            end

            S_FLUSH: begin
                axiov_d = 1'b1;
                axiod_d = part_data;
                last_d  = 1'b1;
                bytes_d = part_bytes;
                pack_d  = '0;
                pcnt_d  = '0;
                state_d = axiiv ? S_FRAME : S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Dibit acceptance is the same in every state. Outside FRAME the fill
        // count is zero, so nothing can pop into the packer there.
        if (axiiv) begin
            dly_d = {dly_q[29:0], axiid};
            if (fill_q == 5'd16) begin
                pack_d = {pack_q[29:0], dly_q[31:30]};
                // A pop after a completed word proves it is not the last one.
                if (pendv_q) begin
                    axiov_d = 1'b1;
                    axiod_d = pend_q;
                    last_d  = 1'b0;
                    bytes_d = 3'd4;
                    pendv_d = 1'b0;
                end
                if (pcnt_q == 5'd15) begin
                    pend_d  = {pack_q[29:0], dly_q[31:30]};
                    pendv_d = 1'b1;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 5'd1;
                end
            end else begin
                fill_d = fill_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            fill_q  <= '0;
            pack_q  <= '0;
            pcnt_q  <= '0;
            pend_q  <= '0;
            pendv_q <= 1'b0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
            last_q  <= 1'b0;
            bytes_q <= '0;
            runt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            fill_q  <= fill_d;
            pack_q  <= pack_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            pendv_q <= pendv_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
            runt_q  <= runt_d;
        end
    end

    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign axiod_last  = last_q;
    assign axiod_bytes = bytes_q;
    assign runt        = runt_q;

endmodule

// File: tb/tb_eth_word_packer.sv
// Testbench for eth_word_packer: table of directed frames with constant
// expectations, a mid-frame reset sequence, and random frames checked
// against a frame-level reference model.
module tb_eth_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [31:0] axiod;
    logic        axiod_last;
    logic [2:0]  axiod_bytes;
    logic        runt;

    eth_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .axiiv      (axiiv),
        .axiid      (axiid),
        .axiov      (axiov),
        .axiod      (axiod),
        .axiod_last (axiod_last),
        .axiod_bytes(axiod_bytes),
        .runt       (runt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        bit          last;
        int          nb;
    } wrd_t;

    wrd_t       obs[$];
    int         runt_obs[$];
    logic [1:0] dq[$];
    int         edg[$];
    int         eend;

    typedef struct {
        string       name;
        int          nd;
        logic [63:0] pay;
        int          npd;
        int          gap;
        int          nw;
        logic [31:0] w0;
        bit          l0;
        logic [31:0] w1;
        int          lb;
        bit          rn;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // edge counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: log words and runt pulses, check outputs hold between pulses
    initial begin
        logic [31:0] pd;
        logic        pl;
        logic [2:0]  pb;
        bit          prst;
        pd = '0; pl = 1'b0; pb = '0; prst = 1'b1;
        forever begin
            @(negedge clk);
            if (axiov) begin
                wrd_t w;
                w.cyc  = cyc;
                w.d    = axiod;
                w.last = axiod_last;
                w.nb   = int'(axiod_bytes);
                obs.push_back(w);
            end else if (!prst) begin
                chk("hold_data", {32'h0, axiod}, {32'h0, pd});
                chk("hold_ctl", {60'h0, axiod_last, axiod_bytes}, {60'h0, pl, pb});
            end
            if (runt) runt_obs.push_back(cyc);
            pd = axiod; pl = axiod_last; pb = axiod_bytes; prst = rst;
        end
    end

    task automatic send_dibits(input int nd, input logic [63:0] pay, input int npd);
        dq.delete();
        edg.delete();
        for (int k = 0; k < nd; k++) begin
            logic [1:0] d;
            d = (k < npd) ? pay[63-2*k -: 2] : 2'($urandom);
            dq.push_back(d);
            axiiv = 1'b1;
            axiid = d;
            @(posedge clk); #1;
            edg.push_back(cyc);
        end
    endtask

    task automatic send_frame(input int nd, input logic [63:0] pay, input int npd, input int gap);
        send_dibits(nd, pay, npd);
        axiiv = 1'b0;
        axiid = 2'($urandom);
        @(posedge clk); #1;
        eend = cyc;
        for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    function automatic logic [7:0] pbyte(input int i);
        return {dq[4*i], dq[4*i+1], dq[4*i+2], dq[4*i+3]};
    endfunction

    // Frame-level reference: everything but the last 16 dibits is payload.
    // A full word is released (last=0) by the next payload dibit after it,
    // otherwise at the end edge with last=1. Whole leftover bytes form a
    // final partial word; fewer than 4 leftover dibits are dropped.
    task automatic model_check(input string nm, input int nd, input bit aborted);
        wrd_t ex[$];
        int   p, f, r, rel, nb;
        logic [31:0] w;
        if (nd >= 16) begin
            p = nd - 16;
            f = p / 16;
            r = p % 16;
            for (int j = 0; j < f; j++) begin
                wrd_t e;
                w = {pbyte(4*j), pbyte(4*j+1), pbyte(4*j+2), pbyte(4*j+3)};
                rel = 16 * (j + 1) + 17;
                e.d = w; e.nb = 4;
                if (rel <= nd) begin
                    e.cyc = edg[rel-1]; e.last = 1'b0; ex.push_back(e);
                end else if (!aborted) begin
                    e.cyc = eend; e.last = 1'b1; ex.push_back(e);
                end
            end
            if (r >= 4 && !aborted) begin
                wrd_t e;
                nb = r / 4;
                w = '0;
                for (int b = 0; b < nb; b++) w[31-8*b -: 8] = pbyte(4*f + b);
                e.cyc = eend; e.d = w; e.last = 1'b1; e.nb = nb;
                ex.push_back(e);
            end
        end
        chk({nm, "_m_nwords"}, 64'(obs.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < obs.size(); i++) begin
            chk({nm, "_m_data"}, {32'h0, obs[i].d}, {32'h0, ex[i].d});
            chk({nm, "_m_last"}, 64'(obs[i].last), 64'(ex[i].last));
            chk({nm, "_m_bytes"}, 64'(obs[i].nb), 64'(ex[i].nb));
            chk({nm, "_m_cycle"}, 64'(obs[i].cyc), 64'(ex[i].cyc));
        end
        if (nd < 16 && !aborted) begin
            chk({nm, "_m_runt"}, 64'(runt_obs.size()), 64'd1);
            if (runt_obs.size() > 0) chk({nm, "_m_runt_cyc"}, 64'(runt_obs[0]), 64'(eend));
        end else begin
            chk({nm, "_m_runt"}, 64'(runt_obs.size()), 64'd0);
        end
    endtask

    task automatic check_tbl(input vec_t v);
        chk({v.name, "_nwords"}, 64'(obs.size()), 64'(v.nw));
        chk({v.name, "_runt"}, 64'(runt_obs.size()), 64'(v.rn));
        if (v.nw >= 1 && obs.size() >= 1) begin
            chk({v.name, "_w0"}, {32'h0, obs[0].d}, {32'h0, v.w0});
            chk({v.name, "_w0_last"}, 64'(obs[0].last), 64'(v.l0));
            chk({v.name, "_w0_bytes"}, 64'(obs[0].nb), (v.nw == 1) ? 64'(v.lb) : 64'd4);
        end
        if (v.nw == 2 && obs.size() >= 2) begin
            chk({v.name, "_w1"}, {32'h0, obs[1].d}, {32'h0, v.w1});
            chk({v.name, "_w1_last"}, 64'(obs[1].last), 64'd1);
            chk({v.name, "_w1_bytes"}, 64'(obs[1].nb), 64'(v.lb));
        end
        if (v.nw > 0 && obs.size() == v.nw)
            chk({v.name, "_end_lat"}, 64'(obs[v.nw-1].cyc), 64'(eend));
        if (v.rn && runt_obs.size() > 0)
            chk({v.name, "_runt_lat"}, 64'(runt_obs[0]), 64'(eend));
    endtask

    task automatic run_vec(input vec_t v);
        send_frame(v.nd, v.pay, v.npd, v.gap);
        check_tbl(v);
        model_check(v.name, v.nd, 1'b0);
        obs.delete();
        runt_obs.delete();
    endtask

    initial begin
        tbl[0] = '{"short",  24, 64'hABCD_0000_0000_0000,  8, 3, 1, 32'hABCD_0000, 1'b1, 32'h0,         2, 1'b0};
        tbl[1] = '{"full",   32, 64'hDEAD_BEEF_0000_0000, 16, 3, 1, 32'hDEAD_BEEF, 1'b1, 32'h0,         4, 1'b0};
        tbl[2] = '{"wpart",  36, 64'h0102_0304_0500_0000, 20, 3, 2, 32'h0102_0304, 1'b0, 32'h0500_0000, 1, 1'b0};
        tbl[3] = '{"runt",   10, 64'h0,                    0, 3, 0, 32'h0,         1'b0, 32'h0,         0, 1'b1};
        tbl[4] = '{"fcsonly",16, 64'h0,                    0, 3, 0, 32'h0,         1'b0, 32'h0,         0, 1'b0};
        tbl[5] = '{"odd",    22, 64'hAA00_0000_0000_0000,  4, 3, 1, 32'hAA00_0000, 1'b1, 32'h0,         1, 1'b0};
        tbl[6] = '{"b2b_a",  36, 64'h1122_3344_5500_0000, 20, 1, 2, 32'h1122_3344, 1'b0, 32'h5500_0000, 1, 1'b0};
        tbl[7] = '{"b2b_b",  32, 64'h6677_8899_0000_0000, 16, 3, 1, 32'h6677_8899, 1'b1, 32'h0,         4, 1'b0};

        rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_axiov", 64'(axiov), 64'd0);
        chk("rst_axiod", {32'h0, axiod}, 64'd0);
        chk("rst_last", 64'(axiod_last), 64'd0);
        chk("rst_bytes", 64'(axiod_bytes), 64'd0);
        chk("rst_runt", 64'(runt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        obs.delete();
        runt_obs.delete();

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset after 40 dibits: the word already released mid-frame stays,
        // nothing else comes out, and the next frame is packed normally.
        send_dibits(40, 64'h0, 0);
        rst = 1'b1; axiiv = 1'b1; axiid = 2'($urandom);
        @(posedge clk); #1;
        rst = 1'b0; axiiv = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("mrst_axiov", 64'(axiov), 64'd0);
        chk("mrst_axiod", {32'h0, axiod}, 64'd0);
        chk("mrst_last", 64'(axiod_last), 64'd0);
        chk("mrst_bytes", 64'(axiod_bytes), 64'd0);
        chk("mrst_runt", 64'(runt), 64'd0);
        model_check("mrst", 40, 1'b1);
        obs.delete();
        runt_obs.delete();
        run_vec(tbl[1]);

        for (int n = 0; n < 40; n++) begin
            int nd;
            int gap;
            nd  = $urandom_range(1, 140);
            gap = $urandom_range(1, 3);
            send_frame(nd, 64'h0, 0, gap);
            model_check("rand", nd, 1'b0);
            obs.delete();
            runt_obs.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
